// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter that funnels NumReq command streams into the single
// write port of the SDRAM command FIFO, locking a grant for up to MaxBurst beats.
module sdram_req_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 8,
  localparam int IdWidth  = $clog2(NumReq)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NumReq-1:0]             i_req_valid,
  input  logic [NumReq*DataWidth-1:0]   i_req_data,
  input  logic [NumReq-1:0]             i_req_last,
  output logic [NumReq-1:0]             o_req_ready,
  output logic [IdWidth+DataWidth-1:0]  o_fifo_wr_data,
  output logic                          o_fifo_wr_en,
  input  logic                          i_fifo_full,
  output logic [IdWidth-1:0]            o_grant_id,
  output logic                          o_busy
);

  localparam int CntWidth = $clog2(MaxBurst + 1);
  localparam logic [CntWidth-1:0] LastBeat = CntWidth'(MaxBurst - 1);
  localparam logic [IdWidth-1:0]  RrReset  = IdWidth'(NumReq - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [IdWidth-1:0]     owner_r, owner_nxt_s;
  logic [IdWidth-1:0]     rr_ptr_r, rr_nxt_s;
  logic [CntWidth-1:0]    beat_cnt_r, cnt_nxt_s;

  logic [IdWidth-1:0]     pick_s;
  logic                   pick_found_s;
  logic                   xfer_s;
  logic [DataWidth-1:0]   owner_data_s;

  // (base + offs) mod NumReq; offs never exceeds NumReq so one subtraction suffices.
  function automatic logic [IdWidth-1:0] rr_index(input logic [IdWidth-1:0] base,
                                                  input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NumReq) begin
      sum = sum - NumReq;
    end else begin
      sum = sum;
    end
    return IdWidth'(sum);
  endfunction

  // Round-robin search starting just after the last owner served.
  always_comb begin
    pick_s       = '0;
    pick_found_s = 1'b0;
    for (int i = 1; i <= NumReq; i++) begin
      if (!pick_found_s && i_req_valid[rr_index(rr_ptr_r, i)]) begin
        pick_s       = rr_index(rr_ptr_r, i);
        pick_found_s = 1'b1;
      end else begin
        pick_s       = pick_s;
      end
    end
  end

  assign xfer_s       = i_req_valid[owner_r] & ~i_fifo_full;
  assign owner_data_s = i_req_data[int'(owner_r)*DataWidth +: DataWidth];

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    rr_nxt_s       = rr_ptr_r;
    cnt_nxt_s      = beat_cnt_r;
    o_req_ready    = '0;
    o_fifo_wr_en   = 1'b0;
    o_fifo_wr_data = '0;
    o_grant_id     = '0;
    o_busy         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = ST_OWN;
          owner_nxt_s = pick_s;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_OWN: begin
        o_busy               = 1'b1;
        o_grant_id           = owner_r;
        o_fifo_wr_data       = {owner_r, owner_data_s};
        o_fifo_wr_en         = xfer_s;
        o_req_ready[owner_r] = xfer_s;
        // A silent owner keeps the grant; valid/last only matter on a transfer.
        if (xfer_s) begin
          cnt_nxt_s = beat_cnt_r + CntWidth'(1);
          if (i_req_last[owner_r] || (beat_cnt_r == LastBeat)) begin
            state_nxt_s = ST_IDLE;
            rr_nxt_s    = owner_r;
          end else begin
            state_nxt_s = ST_OWN;
          end
        end else begin
          state_nxt_s = ST_OWN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= RrReset;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      owner_r    <= owner_nxt_s;
      rr_ptr_r   <= rr_nxt_s;
      beat_cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench: cycle-level behavioural model of the arbitration rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sdram_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic [IW+DW-1:0]  wr_data;
  logic              wr_en, full;
  logic [IW-1:0]     grant_id;
  logic              busy;

  always #5 clk = ~clk;

  sdram_req_arbiter #(.NumReq(NR), .DataWidth(DW), .MaxBurst(MB)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_fifo_wr_data(wr_data),
    .o_fifo_wr_en(wr_en), .i_fifo_full(full), .o_grant_id(grant_id), .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester plans: beats left in burst, beats sent so far, refill, stall
  int rem[NR];
  int seq[NR];
  bit cont[NR];
  bit stall[NR];

  // behavioural model: is anyone owning, who, who was served last, beats this grant
  bit m_ok = 1'b0;
  bit m_own = 1'b0;
  int m_owner = 0;
  int m_rr = NR - 1;
  int m_cnt = 0;
  bit n_own;
  int n_owner, n_rr, n_cnt;
  bit acc[NR];

  int ids[$];
  int wcyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] beat(input int k, input int s);
    return {8'(k), 24'(s)};
  endfunction

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k] = (rem[k] > 0) && !stall[k];
      req_last[k]  = (rem[k] == 1);
      req_data[k*DW +: DW] = beat(k, seq[k]);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < NR; k++) begin
      rem[k] = 0; seq[k] = 0; cont[k] = 1'b0; stall[k] = 1'b0;
    end
  endtask

  // Compare DUT outputs with the model at the falling edge and compute the model's next step.
  task automatic sample();
    logic [NR-1:0]    e_ready;
    logic [IW+DW-1:0] e_data;
    bit               e_en, e_busy, x;
    int               e_grant;
    @(negedge clk);
    e_ready = '0; e_data = '0; e_en = 1'b0; e_busy = 1'b0; e_grant = 0;
    n_own = m_own; n_owner = m_owner; n_rr = m_rr; n_cnt = m_cnt;
    for (int k = 0; k < NR; k++) acc[k] = 1'b0;
    if (m_own) begin
      x = req_valid[m_owner] && !full;
      e_busy = 1'b1;
      e_grant = m_owner;
      e_data = {IW'(m_owner), req_data[m_owner*DW +: DW]};
      e_en = x;
      e_ready[m_owner] = x;
      if (x) begin
        acc[m_owner] = 1'b1;
        n_cnt = m_cnt + 1;
        if (req_last[m_owner] || n_cnt == MB) begin
          n_own = 1'b0;
          n_rr = m_owner;
        end
      end
    end else begin
      for (int j = 1; j <= NR; j++) begin
        if (!n_own && req_valid[(m_rr + j) % NR]) begin
          n_own = 1'b1;
          n_owner = (m_rr + j) % NR;
          n_cnt = 0;
        end
      end
    end
    if (rst) begin
      n_own = 1'b0; n_owner = 0; n_rr = NR - 1; n_cnt = 0;
    end
    if (m_ok) begin
      chk("m_ready", 64'(req_ready), 64'(e_ready));
      chk("m_wr_en", 64'(wr_en), 64'(e_en));
      chk("m_wr_data", 64'(wr_data), 64'(e_data));
      chk("m_grant", 64'(grant_id), 64'(e_grant));
      chk("m_busy", 64'(busy), 64'(e_busy));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) m_ok = 1'b1;
    m_own = n_own; m_owner = n_owner; m_rr = n_rr; m_cnt = n_cnt;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) begin
        seq[k]++;
        rem[k]--;
        if (rem[k] == 0 && cont[k]) rem[k] = 1;
      end
    end
    drive();
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    full = 1'b0;
    clear_plan();
    drive();
    tick();
    tick();
    rst = 1'b0;
    drive();
  endtask

  task automatic record(input int n);
    ids.delete();
    wcyc.delete();
    repeat (n) begin
      sample();
      if (wr_en) begin
        ids.push_back(int'(wr_data[IW+DW-1:DW]));
        wcyc.push_back(cyc);
      end
      advance();
    end
  endtask

  initial begin
    int exp_rr[6];
    int exp_cap[13];
    rst = 1'b1;
    full = 1'b0;
    clear_plan();
    drive();
    do_reset();

    // reset state
    sample();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    advance();

    // single requester: req 2, three beats
    rem[2] = 3;
    drive();
    sample();
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_en", 64'(wr_en), 64'd0);
    advance();
    for (int b = 0; b < 3; b++) begin
      sample();
      chk("t1_grant", 64'(grant_id), 64'd2);
      chk("t1_en", 64'(wr_en), 64'd1);
      chk("t1_data", 64'(wr_data), 64'({2'd2, 32'h0200_0000 + 32'(b)}));
      advance();
    end
    sample();
    chk("t1_done_busy", 64'(busy), 64'd0);
    chk("t1_done_en", 64'(wr_en), 64'd0);
    advance();

    // round-robin, all continuously valid with 1-beat bursts
    do_reset();
    for (int k = 0; k < NR; k++) begin
      cont[k] = 1'b1;
      rem[k] = 1;
    end
    drive();
    record(14);
    exp_rr = '{0, 1, 2, 3, 0, 1};
    chk("t2_count_ge6", 64'(ids.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < ids.size(); i++) begin
      chk("t2_order", 64'(ids[i]), 64'(exp_rr[i]));
      if (i > 0) chk("t2_spacing", 64'(wcyc[i] - wcyc[i-1]), 64'd2);
    end

    // MaxBurst cap: req 1 streams 12 beats, req 3 waits with one beat
    do_reset();
    rem[1] = 12;
    rem[3] = 1;
    drive();
    record(30);
    exp_cap = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 1, 1, 1};
    chk("t3_count", 64'(ids.size()), 64'd13);
    for (int i = 0; i < 13 && i < ids.size(); i++) begin
      chk("t3_order", 64'(ids[i]), 64'(exp_cap[i]));
    end

    // backpressure with last presented while full
    do_reset();
    rem[0] = 4;
    drive();
    tick();
    for (int b = 0; b < 3; b++) begin
      sample();
      chk("t4_data", 64'(wr_data), 64'({2'd0, 32'(b)}));
      advance();
    end
    full = 1'b1;
    repeat (4) begin
      sample();
      chk("t4_full_en", 64'(wr_en), 64'd0);
      chk("t4_full_ready", 64'(req_ready), 64'd0);
      chk("t4_full_busy", 64'(busy), 64'd1);
      advance();
    end
    full = 1'b0;
    sample();
    chk("t4_last_en", 64'(wr_en), 64'd1);
    chk("t4_last_data", 64'(wr_data), 64'({2'd0, 32'd3}));
    advance();
    sample();
    chk("t4_done_busy", 64'(busy), 64'd0);
    advance();

    // owner stall while others wait
    do_reset();
    rem[0] = 5;
    cont[1] = 1'b1; rem[1] = 1;
    cont[2] = 1'b1; rem[2] = 1;
    drive();
    tick();
    tick();
    tick();
    stall[0] = 1'b1;
    drive();
    repeat (3) begin
      sample();
      chk("t5_stall_grant", 64'(grant_id), 64'd0);
      chk("t5_stall_en", 64'(wr_en), 64'd0);
      chk("t5_stall_busy", 64'(busy), 64'd1);
      advance();
    end
    stall[0] = 1'b0;
    drive();
    sample();
    chk("t5_resume_en", 64'(wr_en), 64'd1);
    chk("t5_resume_data", 64'(wr_data), 64'({2'd0, 32'd2}));
    advance();
    repeat (12) tick();

    // reset in the middle of a 5-beat burst
    do_reset();
    rem[1] = 5;
    drive();
    tick();
    tick();
    tick();
    rst = 1'b1;
    stall[1] = 1'b1;
    drive();
    tick();
    rst = 1'b0;
    for (int k = 0; k < NR; k++) begin
      stall[k] = 1'b0;
      cont[k] = 1'b1;
      rem[k] = 1;
    end
    drive();
    sample();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_en", 64'(wr_en), 64'd0);
    chk("t6_ready", 64'(req_ready), 64'd0);
    chk("t6_grant", 64'(grant_id), 64'd0);
    chk("t6_data", 64'(wr_data), 64'd0);
    advance();
    sample();
    chk("t6_first_grant", 64'(grant_id), 64'd0);
    chk("t6_first_busy", 64'(busy), 64'd1);
    advance();

    // randomized traffic
    do_reset();
    repeat (3000) begin
      for (int k = 0; k < NR; k++) begin
        if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = $urandom_range(1, 12);
        stall[k] = ($urandom_range(0, 4) == 0);
      end
      full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      drive();
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
